// File: rtl/tracker_pkg.sv
// Shared constants for the min/max statistics tracker.
package tracker_pkg;

  // Tracker state encoding
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Values min/max take when no sample has been seen yet
  localparam logic [3:0] MIN_INIT = 4'hF;
  localparam logic [3:0] MAX_INIT = 4'h0;

  // One comparator result; exactly one field is set
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_t;

endpackage

// File: rtl/comparator4bit.sv
// Unsigned 4-bit magnitude comparator: a vs b.
module comparator4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       lt,
  output logic       eq,
  output logic       gt
);

  // Pure combinational compare; one-hot by construction
  always_comb begin
    lt = (a <  b);
    eq = (a == b);
    gt = (a >  b);
  end

endmodule

// File: rtl/minmax_tracker.sv
// Running min/max/count/equal-run statistics over a valid/ready sample stream.
module minmax_tracker
  import tracker_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  output logic [3:0]       min_out,
  output logic [3:0]       max_out,
  output logic [CNT_W-1:0] count,
  output logic [RUN_W-1:0] eq_run,
  output logic             new_min,
  output logic             new_max,
  output logic             stats_vld
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  logic [1:0]       state;
  logic [3:0]       last;
  logic             accept;
  logic [CNT_W-1:0] cnt_nxt;
  cmp_t             c_max, c_min, c_last;
  logic             unused_cmp;

  // Sample vs. stored max, stored min and previous sample
  comparator4bit u_cmp_max  (.a(in_data), .b(max_out), .lt(c_max.lt),  .eq(c_max.eq),  .gt(c_max.gt));
  comparator4bit u_cmp_min  (.a(in_data), .b(min_out), .lt(c_min.lt),  .eq(c_min.eq),  .gt(c_min.gt));
  comparator4bit u_cmp_last (.a(in_data), .b(last),    .lt(c_last.lt), .eq(c_last.eq), .gt(c_last.gt));

  // Only the strict direction matters for min/max; remaining flags are informational
  assign unused_cmp = ^{c_max.lt, c_max.eq, c_min.eq, c_min.gt, c_last.lt, c_last.gt};

  // Ready drops when saturated or while a restart is being requested
  always_comb begin
    in_ready = (state != ST_FULL) && !clear;
    accept   = in_valid && in_ready;
    cnt_nxt  = count + CNT_W'(1);
  end

  // State and statistics registers; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= ST_EMPTY;
      min_out   <= MIN_INIT;
      max_out   <= MAX_INIT;
      last      <= 4'h0;
      count     <= '0;
      eq_run    <= '0;
      new_min   <= 1'b0;
      new_max   <= 1'b0;
      stats_vld <= 1'b0;
    end else begin
      new_min <= 1'b0;
      new_max <= 1'b0;
      if (accept) begin
        count     <= cnt_nxt;
        last      <= in_data;
        stats_vld <= 1'b1;
        if (state == ST_EMPTY) begin
          // First sample seeds every reference regardless of comparisons
          min_out <= in_data;
          max_out <= in_data;
          eq_run  <= RUN_W'(1);
          new_min <= 1'b1;
          new_max <= 1'b1;
        end else begin
          if (c_max.gt) begin
            max_out <= in_data;
            new_max <= 1'b1;
          end
          if (c_min.lt) begin
            min_out <= in_data;
            new_min <= 1'b1;
          end
          if (c_last.eq)
            eq_run <= (eq_run == RUN_MAX) ? eq_run : eq_run + RUN_W'(1);
          else
            eq_run <= RUN_W'(1);
        end
        state <= (cnt_nxt == CNT_MAX) ? ST_FULL : ST_TRACK;
      end
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed scoreboard bench for minmax_tracker (CNT_W=3, RUN_W=2 to reach saturation quickly).
module tb_minmax_tracker;

  localparam int CNT_W = 3;
  localparam int RUN_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [3:0]       in_data = 4'h0;
  logic             in_ready;
  logic [3:0]       min_out, max_out;
  logic [CNT_W-1:0] count;
  logic [RUN_W-1:0] eq_run;
  logic             new_min, new_max, stats_vld;

  typedef struct {
    int    mn, mx, cnt, run, nmin, nmax, sv, rdy;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  minmax_tracker #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .min_out(min_out), .max_out(max_out), .count(count),
    .eq_run(eq_run), .new_min(new_min), .new_max(new_max), .stats_vld(stats_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", tag, fld, got, want);
    end
  endtask

  // Monitor: outputs settle one cycle after the edge that consumed each drive
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "min",   int'(min_out),   e.mn);
        chk(e.tag, "max",   int'(max_out),   e.mx);
        chk(e.tag, "count", int'(count),     e.cnt);
        chk(e.tag, "eqrun", int'(eq_run),    e.run);
        chk(e.tag, "nmin",  int'(new_min),   e.nmin);
        chk(e.tag, "nmax",  int'(new_max),   e.nmax);
        chk(e.tag, "svld",  int'(stats_vld), e.sv);
        chk(e.tag, "rdy",   int'(in_ready),  e.rdy);
      end
    end
  end

  // Drive one cycle of inputs and queue the hand-computed post-edge outputs.
  // rdy is in_ready seen after the edge with this cycle's clear still applied.
  task automatic step(input string tag, input logic r, input logic c, input logic v,
                      input logic [3:0] d, input int mn, input int mx, input int cnt,
                      input int run, input int nmin, input int nmax, input int sv,
                      input int rdy);
    exp_t e;
    @(negedge clk);
    rst = r; clear = c; in_valid = v; in_data = d;
    e.mn = mn; e.mx = mx; e.cnt = cnt; e.run = run; e.nmin = nmin; e.nmax = nmax;
    e.sv = sv; e.rdy = rdy; e.tag = tag;
    exp_q.push_back(e);
  endtask

  initial begin
    // 1: reset, then first sample
    step("rst",    1, 0, 0, 4'h0, 'hF, 0, 0, 0, 0, 0, 0, 1);
    step("first7", 0, 0, 1, 4'h7,  7,  7, 1, 1, 1, 1, 1, 1);
    // 2: 7,2,A,2
    step("clr2",   0, 1, 0, 4'h0, 'hF, 0, 0, 0, 0, 0, 0, 0);
    step("s2_7",   0, 0, 1, 4'h7,  7,  7, 1, 1, 1, 1, 1, 1);
    step("s2_2",   0, 0, 1, 4'h2,  2,  7, 2, 1, 1, 0, 1, 1);
    step("s2_A",   0, 0, 1, 4'hA,  2, 10, 3, 1, 0, 1, 1, 1);
    step("s2_2b",  0, 0, 1, 4'h2,  2, 10, 4, 1, 0, 0, 1, 1);
    // 3: equal runs and RUN_W saturation
    step("clr3",   0, 1, 0, 4'h0, 'hF, 0, 0, 0, 0, 0, 0, 0);
    step("s3_5a",  0, 0, 1, 4'h5,  5,  5, 1, 1, 1, 1, 1, 1);
    step("s3_5b",  0, 0, 1, 4'h5,  5,  5, 2, 2, 0, 0, 1, 1);
    step("s3_5c",  0, 0, 1, 4'h5,  5,  5, 3, 3, 0, 0, 1, 1);
    step("s3_3",   0, 0, 1, 4'h3,  3,  5, 4, 1, 1, 0, 1, 1);
    step("clr3b",  0, 1, 0, 4'h0, 'hF, 0, 0, 0, 0, 0, 0, 0);
    step("run1",   0, 0, 1, 4'h5,  5,  5, 1, 1, 1, 1, 1, 1);
    step("run2",   0, 0, 1, 4'h5,  5,  5, 2, 2, 0, 0, 1, 1);
    step("run3",   0, 0, 1, 4'h5,  5,  5, 3, 3, 0, 0, 1, 1);
    step("run4",   0, 0, 1, 4'h5,  5,  5, 4, 3, 0, 0, 1, 1);
    step("run5",   0, 0, 1, 4'h5,  5,  5, 5, 3, 0, 0, 1, 1);
    step("run6",   0, 0, 1, 4'h5,  5,  5, 6, 3, 0, 0, 1, 1);
    // 4: fill to 7 samples -> FULL, then frozen, then clear
    step("clr4",   0, 1, 0, 4'h0, 'hF, 0, 0, 0, 0, 0, 0, 0);
    step("f1",     0, 0, 1, 4'h4,  4,  4, 1, 1, 1, 1, 1, 1);
    step("f2",     0, 0, 1, 4'h6,  4,  6, 2, 1, 0, 1, 1, 1);
    step("f3",     0, 0, 1, 4'h2,  2,  6, 3, 1, 1, 0, 1, 1);
    step("f4",     0, 0, 1, 4'h2,  2,  6, 4, 2, 0, 0, 1, 1);
    step("f5",     0, 0, 1, 4'h2,  2,  6, 5, 3, 0, 0, 1, 1);
    step("f6",     0, 0, 1, 4'h9,  2,  9, 6, 1, 0, 1, 1, 1);
    step("f7",     0, 0, 1, 4'h0,  0,  9, 7, 1, 1, 0, 1, 0);
    step("fullF",  0, 0, 1, 4'hF,  0,  9, 7, 1, 0, 0, 1, 0);
    step("fullF2", 0, 0, 1, 4'hF,  0,  9, 7, 1, 0, 0, 1, 0);
    step("fclr",   0, 1, 1, 4'hF, 'hF, 0, 0, 0, 0, 0, 0, 0);
    step("fidle",  0, 0, 0, 4'h0, 'hF, 0, 0, 0, 0, 0, 0, 1);
    // 5: clear with a valid sample drops it
    step("s5_3",   0, 0, 1, 4'h3,  3,  3, 1, 1, 1, 1, 1, 1);
    step("s5_clr", 0, 1, 1, 4'h0, 'hF, 0, 0, 0, 0, 0, 0, 0);
    step("s5_idl", 0, 0, 0, 4'h0, 'hF, 0, 0, 0, 0, 0, 0, 1);
    // 6: valid toggling; pulses only after accepting cycles
    step("t1",     0, 0, 1, 4'h1,  1,  1, 1, 1, 1, 1, 1, 1);
    step("t1i",    0, 0, 0, 4'h9,  1,  1, 1, 1, 0, 0, 1, 1);
    step("t2",     0, 0, 1, 4'h2,  1,  2, 2, 1, 0, 1, 1, 1);
    step("t2i",    0, 0, 0, 4'h0,  1,  2, 2, 1, 0, 0, 1, 1);
    step("t3",     0, 0, 1, 4'h3,  1,  3, 3, 1, 0, 1, 1, 1);
    step("t3i",    0, 0, 0, 4'h3,  1,  3, 3, 1, 0, 0, 1, 1);
    // rst wins over clear and a valid sample mid-stream
    step("rstmid", 1, 1, 1, 4'h8, 'hF, 0, 0, 0, 0, 0, 0, 0);
    step("after",  0, 0, 1, 4'h8,  8,  8, 1, 1, 1, 1, 1, 1);

    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1);
  end

endmodule
